uart_transmitter: RTL
=====================

Name: uart_transmitter

Overview:
- Serialises one byte per request into an asynchronous UART frame on TxD: 1 start bit (0), 8 data bits MSB-first, 1 even-parity bit, 1 stop bit (1).
- Pairs with the UART receiver in the same design. Both use the same frame format, the same bit order, the same parity rule and the same baud_select encoding.
- Internally instantiates baud_controller (rst, clk, baud_select, sample_enable). Bit timing is counted in sample_enable ticks, 16 ticks per bit.

Parameters:
SAMPLES_PER_BIT, 16, number of sample_enable ticks per transmitted bit. Must match the receiver's oversampling.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
Tx_DATA  input  8  byte to send; sampled only on an accepted write.
baud_select  input  3  baud rate select, passed unchanged to baud_controller.
Tx_EN  input  1  transmitter enable; a write is accepted only while high.
Tx_WR  input  1  write strobe, one clk cycle, level-sampled.
TxD  output  1  serial line, registered; idles high.
Tx_BUSY  output  1  high while a frame is in progress.
Tx_DONE  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: TxD=1, Tx_BUSY=0, Tx_DONE=0, state=IDLE, tick counter=0, bit counter=0, shift register=0, parity register=0.
- Reset asserted mid-frame: TxD returns to 1 immediately (asynchronous) and the frame is abandoned.
- State machine states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TxD=1.
  - Accept a write when Tx_WR=1, Tx_EN=1 and state=IDLE.
  - On accept: latch Tx_DATA into the shift register, latch parity = XOR of all 8 bits, clear the tick counter, go to START.
  - On the next edge, TxD=0 and Tx_BUSY=1 (accept-to-line latency is 1 clk).
- Tick counting, all bit states: the tick counter increments on each sample_enable. On the tick where the counter equals 15, the state advances and the counter clears. Each bit therefore spans exactly 16 sample_enable ticks. START may additionally contain the partial tick period before its first tick.
- START: TxD=0. After 16 ticks go to DATA with the bit counter at 0.
- DATA:
  - TxD = shift register MSB.
  - After every 16 ticks, shift left by one and increment the bit counter.
  - On the tick that completes bit 7, go to PARITY.
- PARITY: TxD = latched parity (even parity, so data plus parity carries an even number of 1s). After 16 ticks go to STOP.
- STOP:
  - TxD=1.
  - After 16 ticks: go to IDLE, Tx_BUSY=0, and pulse Tx_DONE for exactly one clk.
  - A write presented in the same cycle that IDLE is entered is accepted on the following edge. Back-to-back frames therefore have no idle gap beyond 1–2 clk.
- Write while busy (Tx_BUSY=1): ignored. The frame in flight is unaffected and Tx_DATA changes have no effect.
- Write with Tx_EN=0: ignored.
- Tx_EN dropped mid-frame: the current frame completes normally. No new writes are accepted.
- baud_select changed mid-frame: not supported. Line timing is undefined until the next IDLE.
- TxD is driven directly from a flop, glitch-free; no combinational path from any input to TxD.
- Frame length: 11 bits = 176 sample_enable ticks, plus the START entry offset of at most one tick.

Test Plan:
- Basic frame: reset, Tx_EN=1, Tx_WR pulse with Tx_DATA=0xA5 -> TxD sequence 0 | 1,0,1,0,0,1,0,1 | 0 (parity) | 1. Each bit lasts 16 ticks; Tx_BUSY high throughout; one Tx_DONE pulse; TxD=1 afterwards.
- Parity odd-weight: Tx_DATA=0x07 -> parity bit 1. Tx_DATA=0x00 -> data bits all 0 and parity bit 0. Loopback into the UART receiver reports Rx_DATA=0x07 and 0x00 with no parity or framing error.
- Ignored writes: while sending 0x3C, pulse Tx_WR with 0xFF mid-DATA -> line still carries 0x3C and exactly one Tx_DONE. A Tx_WR pulse with Tx_EN=0 in IDLE -> TxD stays 1 and Tx_BUSY stays 0.
- Back-to-back: issue 0x55, then 0xAA in the Tx_DONE cycle -> second start bit begins within 2 clk of the end of the first stop bit. Receiver loopback yields 0x55 then 0xAA.
- Reset mid-frame: assert rst during DATA bit 3 of 0xF0 -> TxD=1 and Tx_BUSY=0 immediately with no clk edge. After release, a write of 0x81 transmits correctly.
- All baud_select values 0–7 with 0x5A in loopback against the receiver -> correct reception. Measured bit period = 16 × the sample_enable period for each setting.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART transmitter: 1 start, 8 data bits MSB-first, even parity, 1 stop.
// Bit timing is counted in oversampling ticks from the internal baud_controller.
module uart_transmitter #(
  parameter int SAMPLES_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Tx_DATA,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  output logic       TxD,
  output logic       Tx_BUSY,
  output logic       Tx_DONE
);

  localparam int TICK_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLES_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic              sample_enable;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_reg;
  logic              parity_bit;
  logic              bit_end;

  baud_controller u_baud (
    .rst          (rst),
    .clk          (clk),
    .baud_select  (baud_select),
    .sample_enable(sample_enable)
  );

  assign bit_end = sample_enable && (tick_cnt == TICK_LAST);

  // TxD is set together with each state change so the line always comes from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      TxD        <= 1'b1;
      Tx_BUSY    <= 1'b0;
      Tx_DONE    <= 1'b0;
    end else begin
      Tx_DONE <= 1'b0;
      if (state != IDLE && sample_enable)
        tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
      case (state)
        IDLE: begin
          TxD     <= 1'b1;
          Tx_BUSY <= 1'b0;
          if (Tx_WR && Tx_EN) begin
            shift_reg  <= Tx_DATA;
            parity_bit <= ^Tx_DATA;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            state      <= START;
            TxD        <= 1'b0;
            Tx_BUSY    <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
            TxD     <= shift_reg[7];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_reg <= {shift_reg[6:0], 1'b0};
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
              TxD   <= parity_bit;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              TxD     <= shift_reg[6];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            TxD   <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            state   <= IDLE;
            Tx_BUSY <= 1'b0;
            Tx_DONE <= 1'b1;
            TxD     <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          TxD     <= 1'b1;
          Tx_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// Oversampling tick generator shared with the receiver: one sample_enable
// pulse every (16 - 2*baud_select) clk cycles.
module baud_controller (
  input  logic       rst,
  input  logic       clk,
  input  logic [2:0] baud_select,
  output logic       sample_enable
);

  logic [4:0] div_cnt;
  logic [4:0] div_last;

  always_comb begin
    div_last = 5'd15;
    case (baud_select)
      3'd0:    div_last = 5'd15;
      3'd1:    div_last = 5'd13;
      3'd2:    div_last = 5'd11;
      3'd3:    div_last = 5'd9;
      3'd4:    div_last = 5'd7;
      3'd5:    div_last = 5'd5;
      3'd6:    div_last = 5'd3;
      default: div_last = 5'd1;
    endcase
  end

  // >= keeps the divider from running past a shortened period after a rate change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt       <= '0;
      sample_enable <= 1'b0;
    end else if (div_cnt >= div_last) begin
      div_cnt       <= '0;
      sample_enable <= 1'b1;
    end else begin
      div_cnt       <= div_cnt + 1'b1;
      sample_enable <= 1'b0;
    end
  end

endmodule
